// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I opcode constants, immediate format codes and range helper.
package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Codes 000-100 line up with the decoder's ImmSrc; R has no immediate.
    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_R = 3'b101
    } fmt_t;

    function automatic logic fitsSigned(input logic [31:0] value, input int unsigned bits);
        logic signed [31:0] upper;
        upper = $signed(value) >>> (bits - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - combinational RV32I field packer: op/fields -> {fmt, word, bad}.
// Build option IMM_CHECK_EN: out-of-range immediates are flagged bad instead of truncated.
module instr_packer
    import rv_isa_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output fmt_t        fmt,
    output logic [31:0] word,
    output logic        bad
);

`ifdef IMM_CHECK_EN
    localparam bit IMM_CHECK = 1'b1;
`else
    localparam bit IMM_CHECK = 1'b0;
`endif

    logic knownOp;
    logic immBad;

    always_comb begin
        fmt     = FMT_R;
        knownOp = 1'b1;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_R:                     fmt = FMT_R;
            OP_BRANCH:                fmt = FMT_B;
            OP_JAL:                   fmt = FMT_J;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            default:                  knownOp = 1'b0;
        endcase
    end

    always_comb begin
        word   = {funct7, rs2, rs1, funct3, rd, op};
        immBad = 1'b0;
        case (fmt)
            FMT_I: begin
                word   = {imm[11:0], rs1, funct3, rd, op};
                immBad = !fitsSigned(imm, 12);
            end
            FMT_S: begin
                word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                immBad = !fitsSigned(imm, 12);
            end
            FMT_B: begin
                word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                immBad = !fitsSigned(imm, 13) || imm[0];
            end
            FMT_J: begin
                word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                immBad = !fitsSigned(imm, 21) || imm[0];
            end
            FMT_U: begin
                word   = {imm[31:12], rd, op};
                immBad = |imm[11:0];
            end
            default: ;
        endcase
    end

    assign bad = !knownOp || (IMM_CHECK && immBad);

endmodule

// File: rtl/instr_encoder_writer.sv
// rtl/instr_encoder_writer.sv - accepts RV32I field requests and streams packed words into IMEM.
// Build option IMM_CHECK_EN (see instr_packer) turns immediate range violations into dropped requests.
module instr_encoder_writer
    import rv_isa_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          base_load,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [2:0]    in_funct3,
    input  logic [6:0]    in_funct7,
    input  logic [31:0]   in_imm,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          full,
    output logic          err,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

    state_t      state;
    logic [31:0] packWord;
    logic        packBad;
    // Format is informational here; word and bad already reflect it.
    fmt_t        unusedFmt;

    instr_packer u_packer (
        .op     (in_op),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .fmt    (unusedFmt),
        .word   (packWord),
        .bad    (packBad)
    );

    // imem_addr doubles as the write pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (base_load) begin
                        imem_addr <= base_addr;
                        count     <= '0;
                    end
                    if (in_valid && in_ready) begin
                        if (packBad) begin
                            err <= 1'b1;
                        end else begin
                            state      <= S_WRITE;
                            in_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_wdata <= packWord;
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_ready) begin
                        imem_we   <= 1'b0;
                        imem_addr <= imem_addr + 1'b1;
                        count     <= count + 1'b1;
                        if (count + 1'b1 == DEPTH_CNT) begin
                            state <= S_FULL;
                            full  <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (base_load) begin
                        state     <= S_IDLE;
                        full      <= 1'b0;
                        in_ready  <= 1'b1;
                        imem_addr <= base_addr;
                        count     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb/tb_instr_encoder_writer.sv - self-checking bench for instr_encoder_writer with a field-level encoding model.
module tb_instr_encoder_writer;

    localparam int AW    = 3;
    localparam int DEPTH = 4;
`ifdef IMM_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          base_load = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic [6:0]    in_op = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          imem_ready = 1'b0;
    logic          in_ready, imem_we, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int   nTests = 0, nFail = 0;
    int   expPtr = 0, expCount = 0;
    logic expErr = 1'b0;

    instr_encoder_writer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .full(full), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: {bad, word} built from the RV32I field placement rules with shifts and masks.
    function automatic logic [32:0] refEnc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] imm);
        logic [31:0] regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        logic [31:0] rdop = (32'(rd) << 7) | 32'(op);
        int          si   = imm;
        logic [31:0] w;
        logic        rangeBad = 1'b0;
        logic        unknown  = 1'b0;
        case (op)
            7'h03, 7'h13, 7'h67: begin
                w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | rdop;
                rangeBad = si < -2048 || si > 2047;
            end
            7'h23: begin
                w = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(op);
                rangeBad = si < -2048 || si > 2047;
            end
            7'h33: w = (32'(f7) << 25) | regs | rdop;
            7'h63: begin
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
                rangeBad = si < -4096 || si > 4095 || imm[0];
            end
            7'h6F: begin
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000) | rdop;
                rangeBad = si < -(1 << 20) || si > (1 << 20) - 1 || imm[0];
            end
            7'h37, 7'h17: begin
                w = (imm & 32'hFFFFF000) | rdop;
                rangeBad = (imm & 32'hFFF) != 0;
            end
            default: begin
                w = '0;
                unknown = 1'b1;
            end
        endcase
        return {unknown | (CHECK & rangeBad), w};
    endfunction

    task automatic loadBase(input logic [AW-1:0] addr);
        base_addr = addr;
        base_load = 1'b1;
        @(posedge clk); #1;
        base_load = 1'b0;
        expPtr = int'(addr);
        expCount = 0;
        chk("base_count", 32'(count), 0);
        chk("base_full", 32'(full), 0);
        chk("base_ready", 32'(in_ready), 1);
        chk("base_addr", 32'(imem_addr), 32'(expPtr));
    endtask

    task automatic doReq(input string tag, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, input int stall, output logic [31:0] got);
        logic [32:0] e = refEnc(op, rd, rs1, rs2, f3, f7, imm);
        int t = 0;
        got = 'x;
        while (in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 1);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; imem_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (e[32]) begin
            expErr = 1'b1;
            chk({tag, "_nowe"}, 32'(imem_we), 0);
            chk({tag, "_cnt"}, 32'(count), 32'(expCount));
        end else begin
            chk({tag, "_we"}, 32'(imem_we), 1);
            chk({tag, "_addr"}, 32'(imem_addr), 32'(expPtr));
            chk({tag, "_data"}, imem_wdata, e[31:0]);
            got = imem_wdata;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_we"}, 32'(imem_we), 1);
                chk({tag, "_hold_addr"}, 32'(imem_addr), 32'(expPtr));
                chk({tag, "_hold_data"}, imem_wdata, e[31:0]);
                chk({tag, "_hold_rdy"}, 32'(in_ready), 0);
            end
            imem_ready = 1'b1;
            @(posedge clk); #1;
            imem_ready = 1'b0;
            expPtr = (expPtr + 1) % (1 << AW);
            expCount++;
            chk({tag, "_done_we"}, 32'(imem_we), 0);
            chk({tag, "_done_cnt"}, 32'(count), 32'(expCount));
            chk({tag, "_done_full"}, 32'(full), 32'(expCount == DEPTH));
            chk({tag, "_done_rdy"}, 32'(in_ready), 32'(expCount != DEPTH));
        end
        chk({tag, "_err"}, 32'(err), 32'(expErr));
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_imem_we"}, 32'(imem_we), 0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_count"}, 32'(count), 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [6:0]  op;
        logic [31:0] imm;

        repeat (2) @(posedge clk);
        #1;
        chkAllZero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 1);
        loadBase('0);

        doReq("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, w);
        chk("addi_word", w, 32'h00500093);
        doReq("sw", 7'h23, 5'd0, 5'd0, 5'd2, 3'b010, 7'd0, 32'd8, 3, w);
        chk("sw_word", w, 32'h00202423);
        doReq("beq", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 0, w);
        chk("beq_word", w, 32'hFE000EE3);
        doReq("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0, w);
        chk("jal_word", w, 32'h008000EF);

        in_valid = 1'b1; in_op = 7'h13; in_imm = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("full_nowe", 32'(imem_we), 0);
            chk("full_rdy", 32'(in_ready), 0);
            chk("full_flag", 32'(full), 1);
        end
        in_valid = 1'b0;
        chk("full_cnt", 32'(count), DEPTH);
        loadBase('0);

        doReq("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, w);
        chk("lui_word", w, 32'h123452B7);
        doReq("unknown", 7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, w);
        doReq("after_bad", 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'd7, 1, w);
        doReq("beq_odd", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 0, w);

        for (int n = 0; n < 40; n++) begin
            if (expCount == DEPTH) loadBase(AW'($urandom_range(0, (1 << AW) - 1)));
            op = ops[$urandom_range(0, 9)];
            case (op)
                7'h03, 7'h13, 7'h67, 7'h23: imm = $urandom_range(0, 4095) - 2048;
                7'h63: imm = ($urandom_range(0, 8191) - 4096) & ~32'h1;
                7'h6F: imm = ($urandom_range(0, (1 << 21) - 1) - (1 << 20)) & ~32'h1;
                7'h37, 7'h17: imm = $urandom & 32'hFFFFF000;
                default: imm = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) imm = $urandom;
            doReq("rand", op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), imm, $urandom_range(0, 2), w);
        end

        if (expCount == DEPTH) loadBase('0);
        while (in_ready !== 1'b1 && expCount < 100) begin
            @(posedge clk); #1;
            expCount++;
        end
        in_valid = 1'b1; in_op = 7'h13; in_rd = 5'd1; in_imm = 32'd9; imem_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid_we", 32'(imem_we), 1);
        #2 reset_n = 1'b0;
        #1;
        chkAllZero("rst_mid");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_rel_ready", 32'(in_ready), 1);
        chk("rst_rel_we", 32'(imem_we), 0);
        chk("rst_rel_cnt", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
